// File: rtl/serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_pkg
//  Description : Shared opcodes, FSM state type and helper functions for the
//                bit-serial ALU controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_pkg;

  localparam logic [2:0] OP_INC = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Arithmetic ops are the lower half of the opcode space.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Value loaded into the carry/borrow flop when a command is accepted.
  // SUB uses A + ~B + 1, DEC starts with a borrow of one.
  function automatic logic carry_init(input logic [2:0] op, input logic cin);
    logic c;
    case (op)
      OP_INC:  c = 1'b1;
      OP_ADD:  c = cin;
      OP_SUB:  c = 1'b1;
      OP_DEC:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_ctrl_if
//  Description : Command/response bundle between a command source and the
//                bit-serial ALU controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cout, ovf, zero
  );

endinterface
`default_nettype wire

// File: rtl/serial_alu_ctrl_onebit.sv
`default_nettype none
// ============================================================================
//  Module      : onebit
//  Description : One-bit ALU slice. S selects INC/ADD/SUB/DEC/AND/OR/XOR/NOT;
//                Cout is the carry (or borrow for DEC), 0 for logic ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module onebit (
  input  logic       A,
  input  logic       B,
  input  logic       Cin,
  input  logic [2:0] S,
  output logic       F,
  output logic       Cout
);

  // Single-bit function select; SUB adds the inverted B operand.
  always_comb begin
    F    = 1'b0;
    Cout = 1'b0;
    case (S)
      3'b000: begin F = A ^ Cin;      Cout = A & Cin; end
      3'b001: begin F = A ^ B ^ Cin;  Cout = (A & B) | (A & Cin) | (B & Cin); end
      3'b010: begin F = A ^ ~B ^ Cin; Cout = (A & ~B) | (A & Cin) | (~B & Cin); end
      3'b011: begin F = A ^ Cin;      Cout = ~A & Cin; end
      3'b100: F = A & B;
      3'b101: F = A | B;
      3'b110: F = A ^ B;
      default: F = ~A;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_ctrl
//  Description : Bit-serial ALU controller. Runs one onebit slice over WIDTH
//                cycles, LSB first, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_alu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             w_f;
  logic             w_cout;
  logic             w_busy;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_next;

  onebit u_slice (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (op_q),
    .F    (w_f),
    .Cout (w_cout)
  );

  assign w_busy     = (state_q == RUN);
  assign w_accept   = bus.start & ~w_busy;
  assign w_res_next = {w_f, res_sh_q[WIDTH-1:1]};

  assign bus.busy   = w_busy;
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

  // Next-state and datapath update: accept, shift one bit per RUN cycle, latch flags on the last bit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      RUN: begin
        res_sh_d = w_res_next;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = is_arith(op_q) ? w_cout : 1'b0;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d  = DONE;
          result_d = w_res_next;
          // carry_q is the carry into the MSB on this final bit
          cout_d   = is_arith(op_q) ? w_cout : 1'b0;
          ovf_d    = is_arith(op_q) ? (carry_q ^ w_cout) : 1'b0;
          zero_d   = (w_res_next == '0);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A start outside RUN wins over the DONE->IDLE fallback
    if (w_accept) begin
      state_d = RUN;
      a_sh_d  = bus.a;
      b_sh_d  = bus.b;
      op_d    = bus.op;
      cnt_d   = '0;
      carry_d = carry_init(bus.op, bus.cin);
    end
  end

  // State and datapath registers; async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial ALU controller. Sequences one 1-bit ALU slice over WIDTH clock cycles, LSB first, to execute a WIDTH-bit operation.
- Holds the operand and result shift registers, the inter-bit carry/borrow flop, the bit counter and a start/busy/done handshake.
- Sits between a simple command source (testbench or control FSM) and the slice. It is the team's multi-bit ALU built from the single-bit cell.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be ≥2.
- CNT_W, $clog2(WIDTH), bit-counter width. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe. Sampled only while busy=0.
- op  in  3  000 INC A, 001 ADD A+B+cin, 010 SUB A-B, 011 DEC A, 100 AND, 101 OR, 110 XOR, 111 NOT A
- a  in  WIDTH  operand A, captured with start
- b  in  WIDTH  operand B, captured with start
- cin  in  1  carry-in for ADD only, captured with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when result is valid
- result  out  WIDTH  final result, held until the next accepted start
- cout  out  1  final carry (INC/ADD/SUB) or borrow (DEC); 0 for logic ops
- ovf  out  1  signed overflow for arithmetic ops; 0 for logic ops
- zero  out  1  result == 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shift registers, carry flop and counter cleared.
  - busy=0, done=0, result=0, cout=0, ovf=0, zero=0.
  - Reset mid-operation aborts; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE when cnt==WIDTH-1.
  - DONE→RUN on start, otherwise DONE→IDLE.
- Accept (edge E0, busy=0 and start=1):
  - Load a_sh=a, b_sh=b, op_q=op, cnt=0.
  - Carry init: INC=1, ADD=cin, SUB=1 (two's complement, slice sees ~B), DEC=1 (borrow), logic ops=0.
  - start while busy=1 is ignored, with no side effects.
- RUN (edges E1..E_WIDTH), each edge:
  - Slice evaluates a_sh[0], b_sh[0], carry.
  - res_sh shifts right, inserting F at the MSB. a_sh and b_sh shift right.
  - carry <= slice Cout for op_q[2]=0. For logic ops carry stays 0.
  - prev_carry <= carry.
  - cnt increments.
- On the edge where cnt==WIDTH-1:
  - result <= completed res_sh (including this edge's F).
  - cout <= final carry (0 for logic).
  - ovf <= carry-into-MSB XOR carry-out (0 for logic).
  - zero <= (completed result == 0).
  - state=DONE.
- Latency: busy=1 for exactly WIDTH cycles after E0. done=1 for one cycle after E_WIDTH, coincident with busy=0.
- result, cout, ovf and zero update only at DONE entry and are otherwise held.
- DEC semantics: diff = A^borrow, borrow_out = ~A & borrow. cout=1 means A was 0.
- SUB semantics: cout=1 means no borrow (A ≥ B unsigned).
- Back-to-back: start in DONE is accepted, giving done and the new busy on consecutive cycles. The full throughput is one op per WIDTH+1 cycles.
- Counter never wraps: it is reloaded to 0 on accept.

Decomposition:
- Shared package serial_alu_pkg:
  - op encodings (OP_INC … OP_NOT)
  - state enum (IDLE, RUN, DONE)
  - helper is_arith(op) = ~op[2]
  - carry-init function of op/cin
- One sub-module: the team's existing one-bit ALU slice `onebit` (ports A, B, Cin, S[2:0], F, Cout), instantiated once and reused unchanged.
- No other hierarchy.

Test Plan (WIDTH=8):
- ADD a=0x7F b=0x01 cin=0 → result=0x80, cout=0, ovf=1, zero=0. busy high 8 cycles, done 1 cycle later.
- SUB a=0x05 b=0x07 → result=0xFE, cout=0, ovf=0. SUB a=0x80 b=0x01 → result=0x7F, cout=1, ovf=1.
- DEC a=0x00 → result=0xFF, cout=1, ovf=0. INC a=0xFF → result=0x00, cout=1, zero=1, ovf=0.
- XOR a=0xA5 b=0xFF → result=0x5A, cout=0, ovf=0. NOT a=0x0F → result=0xF0.
- start pulsed with new operands on cycle 3 of an ADD → ignored. Original result, single done.
- rst_n low in cycle 4 of RUN → all outputs 0 immediately, no done. A new op after release completes correctly. Back-to-back start in the DONE cycle is accepted.
